// File: rtl/cordic_iter.sv
// Iterative CORDIC engine (rotation/vectoring), one micro-rotation per clock.
// Define GAIN_COMP_EN to scale the result by 1/K in one extra cycle before output.
module cordic_iter #(
    parameter int BITS  = 16,
    parameter int STEPS = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic signed [BITS-1:0] in_x,
    input  logic signed [BITS-1:0] in_y,
    input  logic signed [BITS:0]   in_z,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [BITS-1:0] out_x,
    output logic signed [BITS-1:0] out_y,
    output logic signed [BITS:0]   out_z,
    output logic                   busy
);

    localparam int XW    = BITS + 2;
    localparam int ZW    = BITS + 1;
    localparam int FRAC  = BITS - 2;
    localparam int CNT_W = $clog2(STEPS + 2);
    localparam int ROM_N = 1 << CNT_W;
`ifdef GAIN_COMP_EN
    localparam int LAST_CNT = STEPS + 1;
    localparam int PW       = XW + BITS;
    localparam longint GAIN_K_L = ((longint'(6072529) <<< FRAC) + 5000000) / 10000000;
    localparam logic signed [BITS-1:0] GAIN_K   = BITS'(GAIN_K_L);
    localparam logic signed [PW-1:0]   GAIN_RND = PW'(longint'(1) <<< (FRAC - 1));
`else
    localparam int LAST_CNT = STEPS;
`endif
    localparam longint HALF_PI_L = ((longint'(15707963) <<< FRAC) + 5000000) / 10000000;
    localparam logic signed [ZW-1:0] HALF_PI = ZW'(HALF_PI_L);

    // atan(1/d) as a Q60 power series; terms shrink by d^2 so 40 terms is ample for d >= 2
    function automatic longint atan_series(input longint d);
        longint p;
        longint sum;
        longint term;
        p   = (longint'(1) <<< 60) / d;
        sum = 0;
        for (int k = 0; k < 40; k++) begin
            term = p / longint'(2 * k + 1);
            if (k % 2 == 0) sum = sum + term;
            else            sum = sum - term;
            p = p / (d * d);
        end
        return sum;
    endfunction

    // atan(1) = atan(1/2) + atan(1/3) keeps entry 0 on the fast-converging path
    function automatic logic signed [ZW-1:0] atan_entry(input int i);
        longint v;
        if (i == 0) v = atan_series(2) + atan_series(3);
        else        v = atan_series(longint'(1) <<< i);
        return ZW'((v + (longint'(1) <<< (59 - FRAC))) >>> (60 - FRAC));
    endfunction

    function automatic logic signed [BITS-1:0] sat(input logic signed [XW-1:0] v);
        if (v > $signed({3'b000, {(BITS-1){1'b1}}}))
            return {1'b0, {(BITS-1){1'b1}}};
        else if (v < $signed({3'b111, {(BITS-1){1'b0}}}))
            return {1'b1, {(BITS-1){1'b0}}};
        return v[BITS-1:0];
    endfunction

    logic signed [ZW-1:0] atan_rom [ROM_N];

    generate
        for (genvar gi = 0; gi < ROM_N; gi++) begin : g_atan
            if (gi < STEPS) begin : g_used
                localparam logic signed [ZW-1:0] ATAN_I = atan_entry(gi);
                assign atan_rom[gi] = ATAN_I;
            end else begin : g_pad
                assign atan_rom[gi] = '0;
            end
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0] z_q, z_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic signed [BITS-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
    logic signed [ZW-1:0]   out_z_q, out_z_d;

    logic signed [XW-1:0] x_ext, y_ext, x_sh, y_sh;
    logic                 sigma_pos;
`ifdef GAIN_COMP_EN
    logic signed [PW-1:0] prod_x, prod_y;
`endif

    assign x_ext = {{2{in_x[BITS-1]}}, in_x};
    assign y_ext = {{2{in_y[BITS-1]}}, in_y};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        out_z_d   = out_z_q;
        x_sh      = x_q >>> cnt_q;
        y_sh      = y_q >>> cnt_q;
        sigma_pos = mode_q ? y_q[XW-1] : ~z_q[ZW-1];
`ifdef GAIN_COMP_EN
        prod_x    = PW'(x_q) * PW'(GAIN_K);
        prod_y    = PW'(y_q) * PW'(GAIN_K);
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mode_d  = in_mode;
                    cnt_d   = '0;
                    state_d = S_RUN;
                    x_d     = x_ext;
                    y_d     = y_ext;
                    z_d     = in_z;
                    if (!in_mode) begin
                        if (in_z > HALF_PI) begin
                            x_d = -y_ext;
                            y_d = x_ext;
                            z_d = in_z - HALF_PI;
                        end else if (in_z < -HALF_PI) begin
                            x_d = y_ext;
                            y_d = -x_ext;
                            z_d = in_z + HALF_PI;
                        end
                    end else if (in_x[BITS-1]) begin
                        // fold the left half-plane so the iterations only see x >= 0
                        if (!in_y[BITS-1]) begin
                            x_d = y_ext;
                            y_d = -x_ext;
                            z_d = in_z + HALF_PI;
                        end else begin
                            x_d = -y_ext;
                            y_d = x_ext;
                            z_d = in_z - HALF_PI;
                        end
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q < CNT_W'(STEPS)) begin
                    if (sigma_pos) begin
                        x_d = x_q - y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - atan_rom[cnt_q];
                    end else begin
                        x_d = x_q + y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + atan_rom[cnt_q];
                    end
                end
`ifdef GAIN_COMP_EN
                else if (cnt_q == CNT_W'(STEPS)) begin
                    x_d = XW'((prod_x + GAIN_RND) >>> FRAC);
                    y_d = XW'((prod_y + GAIN_RND) >>> FRAC);
                end
`endif
                if (cnt_q == CNT_W'(LAST_CNT)) begin
                    out_x_d = sat(x_q);
                    out_y_d = sat(y_q);
                    out_z_d = z_q;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_z_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_z_q     <= out_z_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_z     = out_z_q;

endmodule

// File: tb/tb_cordic_iter.sv
// Self-checking bench for cordic_iter: directed cases with tolerances plus random
// operands against an integer CORDIC reference built from real-valued atan.
module tb_cordic_iter;
    localparam int BITS  = 16;
    localparam int STEPS = 14;
    localparam int FRAC  = BITS - 2;
`ifdef GAIN_COMP_EN
    localparam int LAT = STEPS + 2;
`else
    localparam int LAT = STEPS + 1;
`endif

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, in_mode, out_valid, out_ready, busy;
    logic signed [BITS-1:0] in_x, in_y, out_x, out_y;
    logic signed [BITS:0]   in_z, out_z;

    int n_checks = 0;
    int n_fail   = 0;
    int atan_tab [STEPS];
    int half_pi, gain_k;

    cordic_iter #(.BITS(BITS), .STEPS(STEPS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
        .out_y(out_y), .out_z(out_z), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sat_ref(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: quadrant fold, STEPS micro-rotations, optional 1/K scaling, saturation
    function automatic void model(input bit mode, input int x0, input int y0, input int z0,
                                  output int ox, output int oy, output int oz);
        int x, y, z, t, xs, ys;
        x = x0; y = y0; z = z0;
        if (!mode) begin
            if (z > half_pi)       begin t = x; x = -y; y = t;  z = z - half_pi; end
            else if (z < -half_pi) begin t = x; x = y;  y = -t; z = z + half_pi; end
        end else if (x < 0) begin
            if (y >= 0) begin t = x; x = y;  y = -t; z = z + half_pi; end
            else        begin t = x; x = -y; y = t;  z = z - half_pi; end
        end
        for (int i = 0; i < STEPS; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if ((!mode && z >= 0) || (mode && y < 0)) begin
                x = x - ys; y = y + xs; z = z - atan_tab[i];
            end else begin
                x = x + ys; y = y - xs; z = z + atan_tab[i];
            end
        end
`ifdef GAIN_COMP_EN
        x = (x * gain_k + (1 << (FRAC - 1))) >>> FRAC;
        y = (y * gain_k + (1 << (FRAC - 1))) >>> FRAC;
`endif
        ox = sat_ref(x);
        oy = sat_ref(y);
        oz = z;
    endfunction

    // Drives one operand from IDLE, waits (bounded) for the result, then takes it.
    task automatic run_op(input bit mode, input int x, input int y, input int z,
                          output int ox, output int oy, output int oz, output int lat);
        in_mode  = mode;
        in_x     = BITS'(x);
        in_y     = BITS'(y);
        in_z     = (BITS+1)'(z);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        ox = out_x;
        oy = out_y;
        oz = out_z;
        $display("op mode=%0d in=(%0d,%0d,%0d) out=(%0d,%0d,%0d) latency=%0d",
                 mode, x, y, z, ox, oy, oz, lat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mode = 1'b0; in_x = '0; in_y = '0; in_z = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if ({out_x, out_y, out_z} !== '0) begin n_fail++; $display("FAIL reset_outputs got (%0d,%0d,%0d) want 0", out_x, out_y, out_z); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int ox, oy, oz, lat;
`ifndef GAIN_COMP_EN
        run_op(1'b0, 9949, 0, 12868, ox, oy, oz, lat);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL rot45_latency got %0d want %0d", lat, LAT); end
        n_checks++; if (iabs(ox - 11585) > 8 || iabs(oy - 11585) > 8) begin n_fail++; $display("FAIL rot45_xy got (%0d,%0d) want 11585+-8", ox, oy); end
        n_checks++; if (iabs(oz) > 4) begin n_fail++; $display("FAIL rot45_z got %0d want 0+-4", oz); end

        run_op(1'b1, 8192, 8192, 0, ox, oy, oz, lat);
        n_checks++; if (iabs(ox - 19079) > 8) begin n_fail++; $display("FAIL vec45_x got %0d want 19079+-8", ox); end
        n_checks++; if (iabs(oy) > 4) begin n_fail++; $display("FAIL vec45_y got %0d want 0+-4", oy); end
        n_checks++; if (iabs(oz - 12868) > 4) begin n_fail++; $display("FAIL vec45_z got %0d want 12868+-4", oz); end

        run_op(1'b1, -8192, 0, 0, ox, oy, oz, lat);
        n_checks++; if (iabs(oz - 51472) > 6) begin n_fail++; $display("FAIL vecq2_z got %0d want 51472+-6", oz); end
        n_checks++; if (iabs(ox - 13490) > 8) begin n_fail++; $display("FAIL vecq2_x got %0d want 13490+-8", ox); end

        run_op(1'b0, 9949, 0, -38604, ox, oy, oz, lat);
        n_checks++; if (iabs(ox + 11585) > 8 || iabs(oy + 11585) > 8) begin n_fail++; $display("FAIL rotm135_xy got (%0d,%0d) want -11585+-8", ox, oy); end
`else
        run_op(1'b0, 16384, 0, 0, ox, oy, oz, lat);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL gain_latency got %0d want %0d", lat, LAT); end
        n_checks++; if (iabs(ox - 16384) > 8) begin n_fail++; $display("FAIL gain_x got %0d want 16384+-8", ox); end
        n_checks++; if (iabs(oy) > 4) begin n_fail++; $display("FAIL gain_y got %0d want 0+-4", oy); end
`endif
    endtask

    task automatic test_zero_vector();
        int ox, oy, oz, lat, ex, ey, ez;
        model(1'b1, 0, 0, 0, ex, ey, ez);
        run_op(1'b1, 0, 0, 0, ox, oy, oz, lat);
        n_checks++; if (ox !== ex || oy !== ey || oz !== ez) begin n_fail++; $display("FAIL zero_vec got (%0d,%0d,%0d) want (%0d,%0d,%0d)", ox, oy, oz, ex, ey, ez); end
    endtask

    task automatic test_backpressure();
        int ex, ey, ez, lat;
        logic signed [BITS-1:0] rx, ry;
        logic signed [BITS:0]   rz;
        model(1'b0, 20000, -7000, 40000, ex, ey, ez);
        in_mode = 1'b0; in_x = 16'sd20000; in_y = -16'sd7000; in_z = 17'sd40000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL bp_latency got %0d want %0d", lat, LAT); end
        rx = out_x; ry = out_y; rz = out_z;
        n_checks++; if (int'(rx) !== ex || int'(ry) !== ey || int'(rz) !== ez) begin n_fail++; $display("FAIL bp_result got (%0d,%0d,%0d) want (%0d,%0d,%0d)", rx, ry, rz, ex, ey, ez); end
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_x     = BITS'(c * 1000);
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready, busy, out_x, out_y, out_z} !== {3'b101, rx, ry, rz}) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got v=%b r=%b b=%b (%0d,%0d,%0d) want v=1 r=0 b=1 (%0d,%0d,%0d)",
                         c, out_valid, in_ready, busy, out_x, out_y, out_z, rx, ry, rz);
            end
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++; if ({in_ready, out_valid, busy} !== 3'b100) begin n_fail++; $display("FAIL bp_release got r=%b v=%b b=%b want r=1 v=0 b=0", in_ready, out_valid, busy); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_capture busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int ox, oy, oz, lat, ex, ey, ez;
        in_mode = 1'b1; in_x = 16'sd12000; in_y = -16'sd9000; in_z = '0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++; if ({in_ready, out_valid, busy} !== 3'b100) begin n_fail++; $display("FAIL midrst_state got r=%b v=%b b=%b want r=1 v=0 b=0", in_ready, out_valid, busy); end
        n_checks++; if ({out_x, out_y, out_z} !== '0) begin n_fail++; $display("FAIL midrst_outputs got (%0d,%0d,%0d) want 0", out_x, out_y, out_z); end
        repeat (LAT + 2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_output got %b want 0", out_valid); end
        model(1'b0, -15000, 6000, -20000, ex, ey, ez);
        run_op(1'b0, -15000, 6000, -20000, ox, oy, oz, lat);
        n_checks++; if (lat !== LAT || ox !== ex || oy !== ey || oz !== ez) begin n_fail++; $display("FAIL midrst_after got (%0d,%0d,%0d) lat %0d want (%0d,%0d,%0d) lat %0d", ox, oy, oz, lat, ex, ey, ez, LAT); end
    endtask

    task automatic test_random();
        int ox, oy, oz, lat, ex, ey, ez, x, y, z;
        bit mode;
        for (int n = 0; n < 24; n++) begin
            mode = 1'($urandom_range(0, 1));
            x = int'($urandom_range(0, 65535)) - 32768;
            y = int'($urandom_range(0, 65535)) - 32768;
            if (mode) z = int'($urandom_range(0, 24000)) - 12000;
            else      z = int'($urandom_range(0, 102944)) - 51472;
            if (n == 0) begin mode = 1'b0; x = -32768; y = -32768; z = 51472; end
            if (n == 1) begin mode = 1'b0; x = 32767;  y = 32767;  z = -51472; end
            model(mode, x, y, z, ex, ey, ez);
            run_op(mode, x, y, z, ox, oy, oz, lat);
            n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", n, lat, LAT); end
            n_checks++; if (ox !== ex) begin n_fail++; $display("FAIL rand%0d_x got %0d want %0d", n, ox, ex); end
            n_checks++; if (oy !== ey) begin n_fail++; $display("FAIL rand%0d_y got %0d want %0d", n, oy, ey); end
            n_checks++; if (oz !== ez) begin n_fail++; $display("FAIL rand%0d_z got %0d want %0d", n, oz, ez); end
        end
    endtask

    initial begin
        for (int i = 0; i < STEPS; i++)
            atan_tab[i] = $rtoi($atan(1.0 / (2.0 ** i)) * 16384.0 + 0.5);
        half_pi = $rtoi(1.5707963 * 16384.0 + 0.5);
        gain_k  = $rtoi(0.6072529 * 16384.0 + 0.5);
        test_reset();
        test_directed();
        test_zero_vector();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
